// File: rtl/weight_loader.sv
// Host config stream to per-neuron weight memory write port.
// Optional running block checksum output: WEIGHT_LOADER_CKSUM_EN.
module weight_loader #(
  parameter int numNeurons   = 30,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [31:0]             s_data,
  output logic [numNeurons-1:0]   wen,
  output logic [addressWidth-1:0] wadd,
  output logic [dataWidth-1:0]    win,
  output logic                    busy,
  output logic                    done,
  output logic                    err
`ifdef WEIGHT_LOADER_CKSUM_EN
  ,
  output logic [15:0]             cksum
`endif
);

  localparam int AW1 = addressWidth + 1;
  localparam logic [16:0] MaxN = 17'(1) << addressWidth;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [15:0]    rem;
  logic [7:0]     nrn;
  logic [AW1-1:0] addr;

  logic        acc;
  logic [15:0] hdr_n;
  logic [7:0]  hdr_k;
  logic        k_ok;
  logic        n_fit;
  logic        n_nz;
  logic        hdr_bad;
  logic        last;

  assign acc     = s_valid & s_ready;
  assign hdr_n   = s_data[15:0];
  assign hdr_k   = s_data[23:16];
  assign k_ok    = int'({24'b0, hdr_k}) < numNeurons;
  assign n_fit   = {1'b0, hdr_n} <= MaxN;
  assign n_nz    = hdr_n != 16'd0;
  assign hdr_bad = n_nz & ~(k_ok & n_fit);
  assign last    = rem == 16'd1;
  assign busy    = state != IDLE;

  logic unused_bits;
  assign unused_bits = ^{s_data[31:24], addr[addressWidth]};

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (acc && n_nz)
          state_n = hdr_bad ? DRAIN : LOAD;
      end
      LOAD: begin
        if (acc && last)
          state_n = DONE;
      end
      DRAIN: begin
        if (acc && last)
          state_n = IDLE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // s_ready comes from next state so it is low exactly while in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_ready <= 1'b1;
      wen     <= '0;
      wadd    <= '0;
      win     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      rem     <= '0;
      nrn     <= '0;
      addr    <= '0;
    end else begin
      state   <= state_n;
      s_ready <= state_n != DONE;
      wen     <= '0;
      done    <= state == DONE;
      err     <= 1'b0;
      if (acc) begin
        case (state)
          IDLE: begin
            rem  <= hdr_n;
            nrn  <= hdr_k;
            addr <= '0;
            err  <= hdr_bad;
          end
          LOAD: begin
            wen  <= numNeurons'(1) << nrn;
            wadd <= addr[addressWidth-1:0];
            win  <= s_data[dataWidth-1:0];
            addr <= addr + AW1'(1);
            rem  <= rem - 16'd1;
          end
          DRAIN: rem <= rem - 16'd1;
          default: ;
        endcase
      end
    end
  end

`ifdef WEIGHT_LOADER_CKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cksum <= '0;
    else if (acc && state == IDLE)
      cksum <= '0;
    else if (acc && state == LOAD)
      cksum <= cksum + 16'(s_data[dataWidth-1:0]);
  end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Randomized bench for weight_loader with an event-order scoreboard.
// Build with WEIGHT_LOADER_CKSUM_EN to also check the checksum.
module tb_weight_loader;

  localparam int NN = 30;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_data;
  logic [NN-1:0] wen;
  logic [AW-1:0] wadd;
  logic [DW-1:0] win;
  logic          busy;
  logic          done;
  logic          err;
`ifdef WEIGHT_LOADER_CKSUM_EN
  logic [15:0]   cksum;
`endif

  weight_loader #(
    .numNeurons(NN),
    .addressWidth(AW),
    .dataWidth(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .wen(wen),
    .wadd(wadd),
    .win(win),
    .busy(busy),
    .done(done),
    .err(err)
`ifdef WEIGHT_LOADER_CKSUM_EN
    ,
    .cksum(cksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k: 0 write, 1 done, 2 err
  typedef struct {
    int            k;
    logic [NN-1:0] w;
    logic [AW-1:0] a;
    logic [15:0]   d;
  } ev_t;

  ev_t         evq[$];
  logic [15:0] fixd[$];
  int          n_chk = 0;
  int          n_err = 0;
  bit          gap_mode = 0;
  bit          blk_open = 0;
  bit          acc_prev = 0;
  bit          wen_prev = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_prev = 0;
      wen_prev = 0;
    end else begin
      ev_t e;
      bit  ok;
      if (err) begin
        ok = evq.size() > 0 && evq[0].k == 2;
        check("err_expected", 32'(ok), 1);
        if (ok) void'(evq.pop_front());
      end
      if (wen != '0) begin
        ok = evq.size() > 0 && evq[0].k == 0;
        check("wr_expected", 32'(ok), 1);
        if (ok) begin
          e = evq.pop_front();
          check("wen", 32'(wen), 32'(e.w));
          check("wadd", 32'(wadd), 32'(e.a));
          check("win", 32'(win), 32'(e.d));
          check("wr_latency", 32'(acc_prev), 1);
        end
      end
      if (done) begin
        ok = evq.size() > 0 && evq[0].k == 1;
        check("done_expected", 32'(ok), 1);
        if (ok) begin
          e = evq.pop_front();
          check("done_latency", 32'(wen_prev), 1);
`ifdef WEIGHT_LOADER_CKSUM_EN
          check("cksum", 32'(cksum), 32'(e.d));
`endif
        end
      end
      wen_prev = wen != '0;
      acc_prev = s_valid & s_ready;
    end
  end

  task automatic send(input logic [31:0] w);
    int   t;
    logic r;
    if (gap_mode)
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    s_valid = 1'b1;
    s_data  = w;
    t = 0;
    forever begin
      @(negedge clk);
      r = s_ready;
      if (blk_open) check("busy_in_block", 32'(busy), 1);
      @(posedge clk);
      if (r) break;
      t++;
      if (t > 50) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    #1;
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic blk(input int k, input int n, input int stop);
    logic [31:0] w;
    logic [15:0] sum;
    bit          ok;
    ev_t         e;
    w = $urandom;
    w[23:16] = k[7:0];
    w[15:0]  = n[15:0];
    send(w);
    if (n == 0) return;
    ok = (k < NN) && (n <= (1 << AW));
    if (!ok) begin
      e = '{2, '0, '0, '0};
      evq.push_back(e);
    end
    blk_open = 1;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      if (i == stop) break;
      w = $urandom;
      if (fixd.size() > 0) w[15:0] = fixd.pop_front();
      send(w);
      if (ok) begin
        e.k = 0;
        e.w = {{(NN-1){1'b0}}, 1'b1} << k;
        e.a = i[AW-1:0];
        e.d = w[15:0];
        evq.push_back(e);
        sum = sum + w[15:0];
      end
    end
    blk_open = 0;
    if (stop >= 0) begin
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_wen", 32'(wen), 0);
      check("rst_ready", 32'(s_ready), 1);
      check("rst_busy", 32'(busy), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
    end else if (ok) begin
      e = '{1, '0, '0, sum};
      evq.push_back(e);
      @(negedge clk);
      check("ready_in_done", 32'(s_ready), 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(s_ready), 1);
    check("reset_wen", 32'(wen), 0);
    check("reset_wadd", 32'(wadd), 0);
    check("reset_win", 32'(win), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_err", 32'(err), 0);
`ifdef WEIGHT_LOADER_CKSUM_EN
    check("reset_cksum", 32'(cksum), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fixd = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    blk(3, 4, -1);
    gap_mode = 1;
    fixd = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    blk(3, 4, -1);
    gap_mode = 0;

    fixd = '{16'hAAAA, 16'hBBBB};
    blk(30, 2, -1);
    fixd = '{16'h1234};
    blk(0, 1, -1);

    blk(7, 0, -1);
    blk(5, 2, -1);

    blk(1, 1024, -1);
    blk(4, 1025, -1);

    blk(1, 4, 2);
    check("post_rst_wadd", 32'(wadd), 0);
    fixd = '{16'h5555};
    blk(2, 1, -1);

    for (int b = 0; b < 40; b++) begin
      gap_mode = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1: blk($urandom_range(0, NN - 1), $urandom_range(1, 8), -1);
        2: blk($urandom_range(NN, 255), $urandom_range(1, 4), -1);
        default: blk($urandom_range(0, 255), 0, -1);
      endcase
    end

    repeat (5) @(posedge clk);
    #1;
    check("events_left", 32'(evq.size()), 0);
    check("end_busy", 32'(busy), 0);
    check("end_ready", 32'(s_ready), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
